// File: rtl/data_mem_pkg.sv
// Shared definitions for the data RAM: FSM encoding, default geometry and the
// byte-lane merge used by both the store path and the trace output.
package data_mem_pkg;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam int unsigned DM_DEPTH_WORDS = 4096;
    localparam logic [31:0] DM_BASE_ADDR   = 32'h0000_0000;

    function automatic logic [31:0] dm_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  byteen);
        logic [31:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (byteen[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_mem_if.sv
// M-stage data-memory request/response bundle between CPU (master) and RAM (slave).
interface data_mem_if;
    import data_mem_pkg::*;

    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;

    modport master (
        output m_data_addr,
        output m_data_wdata,
        output m_data_byteen,
        output m_inst_addr,
        input  m_data_rdata
    );

    modport slave (
        input  m_data_addr,
        input  m_data_wdata,
        input  m_data_byteen,
        input  m_inst_addr,
        output m_data_rdata
    );

endinterface

// File: rtl/data_mem_array.sv
// Word storage with one lane-enabled write port and an asynchronous read port.
module dm_array
    import data_mem_pkg::*;
#(
    parameter  int unsigned DEPTH_WORDS = DM_DEPTH_WORDS,
    localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [3:0]       wr_be_i,
    input  logic [31:0]      wr_data_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [31:0]      rd_data_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_be_i[i]) mem_q[wr_idx_i][8*i +: 8] <= wr_data_i[8*i +: 8];
            end
        end
    end

    // Read sees pre-edge contents, so read-during-write returns the old word.
    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/data_mem.sv
// Data RAM behind the CPU M stage: post-reset clear FSM, window check, store
// counter and sticky fault. Define DM_TRACE_EN to print committed stores.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DM_DEPTH_WORDS,
    parameter logic [31:0] BASE_ADDR   = DM_BASE_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    data_mem_if.slave   bus,
    output logic        ready,
    output logic        fault,
    output logic [31:0] wr_count
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] WIN_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic             fault_q, fault_d;
    logic [31:0]      wr_count_q, wr_count_d;

    logic [31:0]      offset;
    logic             in_range;
    logic             store;
    logic [IDX_W-1:0] cpu_idx;

    logic             arr_we;
    logic [IDX_W-1:0] arr_idx;
    logic [3:0]       arr_be;
    logic [31:0]      arr_data;
    logic [31:0]      rd_word;

    assign offset   = bus.m_data_addr - BASE_ADDR;
    assign in_range = offset < WIN_BYTES;
    assign cpu_idx  = offset[IDX_W+1:2];
    assign store    = bus.m_data_byteen != 4'b0000;

    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        fault_d    = fault_q;
        wr_count_d = wr_count_q;
        arr_we     = 1'b0;
        arr_idx    = cpu_idx;
        arr_be     = bus.m_data_byteen;
        arr_data   = bus.m_data_wdata;

        if (state_q == ST_CLEAR) begin
            // Clear owns the write port; CPU stores are dropped entirely.
            arr_we    = 1'b1;
            arr_idx   = clr_idx_q;
            arr_be    = '1;
            arr_data  = '0;
            clr_idx_d = clr_idx_q + IDX_W'(1);
            if (clr_idx_q == LAST_IDX) state_d = ST_RUN;
        end else if (store) begin
            if (in_range) begin
                arr_we     = 1'b1;
                wr_count_d = wr_count_q + 32'd1;
            end else begin
                fault_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            clr_idx_q  <= '0;
            fault_q    <= 1'b0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            fault_q    <= fault_d;
            wr_count_q <= wr_count_d;
        end
    end

    dm_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk      (clk),
        .we_i     (arr_we),
        .wr_idx_i (arr_idx),
        .wr_be_i  (arr_be),
        .wr_data_i(arr_data),
        .rd_idx_i (cpu_idx),
        .rd_data_o(rd_word)
    );

    assign ready            = state_q == ST_RUN;
    assign fault            = fault_q;
    assign wr_count         = wr_count_q;
    assign bus.m_data_rdata = (ready && in_range) ? rd_word : '0;

`ifdef DM_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && state_q == ST_RUN && store) begin
            if (in_range)
                $display("@%08h: *%08h <= %08h", bus.m_inst_addr,
                         {bus.m_data_addr[31:2], 2'b00},
                         dm_merge(rd_word, bus.m_data_wdata, bus.m_data_byteen));
            else
                $display("@%08h: DM FAULT %08h", bus.m_inst_addr, bus.m_data_addr);
        end
    end
`endif

    logic unused_bits;
    assign unused_bits = ^{bus.m_inst_addr, offset[1:0], offset[31:IDX_W+2]};

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem (DEPTH_WORDS=16) against a word-array model.
module tb_data_mem;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ready;
    logic        fault;
    logic [31:0] wr_count;

    data_mem_if bus ();

    data_mem #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .ready   (ready),
        .fault   (fault),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model
    logic [31:0] m_mem [DEPTH];
    logic        m_ready;
    int          m_clr;
    logic        m_fault;
    logic [31:0] m_count;

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        if (!m_ready || off >= DEPTH * 4) return 32'h0;
        return m_mem[(off / 4) % DEPTH];
    endfunction

    task automatic model_reset();
        m_ready = 1'b0;
        m_clr   = 0;
        m_fault = 1'b0;
        m_count = 32'h0;
    endtask

    task automatic drive(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] pc);
        bus.m_data_addr   = addr;
        bus.m_data_wdata  = wdata;
        bus.m_data_byteen = be;
        bus.m_inst_addr   = pc;
    endtask

    // One clock edge; the model applies the rules to the inputs held across it.
    task automatic step();
        logic [31:0] addr, wdata, off, mask;
        logic [3:0]  be;
        addr  = bus.m_data_addr;
        wdata = bus.m_data_wdata;
        be    = bus.m_data_byteen;
        off   = addr - BASE;
        @(posedge clk);
        #1;
        if (!m_ready) begin
            m_clr++;
            if (m_clr == DEPTH) begin
                m_ready = 1'b1;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
            end
        end else if (be != 4'b0000) begin
            if (off < DEPTH * 4) begin
                mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
                m_mem[off / 4] = (m_mem[off / 4] & ~mask) | (wdata & mask);
                m_count = m_count + 32'd1;
            end else begin
                m_fault = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        drive(32'h0, 32'h0, 4'b0000, 32'h0);
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (ready !== 1'b0 || fault !== 1'b0 || wr_count !== 32'h0 || bus.m_data_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: ready=%b fault=%b wr_count=%h rdata=%h, want 0 0 0 0",
                     ready, fault, wr_count, bus.m_data_rdata);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= DEPTH; c++) begin
            step();
            checks++;
            if (ready !== (c == DEPTH)) begin
                failures++;
                $display("FAIL clear_ready cycle %0d: ready=%b want %b", c, ready, c == DEPTH);
            end
        end
        for (int w = 0; w < DEPTH; w++) begin
            drive(BASE + 32'(w * 4), 32'h0, 4'b0000, 32'h0);
            #1;
            checks++;
            if (bus.m_data_rdata !== 32'h0) begin
                failures++;
                $display("FAIL cleared_word %0d: rdata=%h want 00000000", w, bus.m_data_rdata);
            end
        end
    endtask

    task automatic test_byte_merge();
        drive(32'h8, 32'hDEAD_BEEF, 4'b1111, 32'h3000);
        step();
        drive(32'h8, 32'h0000_AA00, 4'b0010, 32'h3004);
        step();
        drive(32'h8, 32'h0, 4'b0000, 32'h3008);
        #1;
        checks++;
        if (bus.m_data_rdata !== 32'hDEAD_AAEF) begin
            failures++;
            $display("FAIL byte_merge: rdata=%h want deadaaef", bus.m_data_rdata);
        end
        checks++;
        if (wr_count !== 32'd2) begin
            failures++;
            $display("FAIL byte_merge_count: wr_count=%0d want 2", wr_count);
        end
    endtask

    task automatic test_read_during_write();
        drive(32'h4, 32'h1234_5678, 4'b1111, 32'h3010);
        #1;
        checks++;
        if (bus.m_data_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rdw_old: rdata=%h want 00000000", bus.m_data_rdata);
        end
        step();
        drive(32'h4, 32'h0, 4'b0000, 32'h3014);
        #1;
        checks++;
        if (bus.m_data_rdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL rdw_new: rdata=%h want 12345678", bus.m_data_rdata);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr, exp;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 8) addr = BASE + $urandom_range(0, DEPTH * 4 - 1);
            else if ($urandom_range(0, 1) == 0) addr = BASE + $urandom_range(DEPTH * 4, DEPTH * 4 + 63);
            else addr = $urandom;
            drive(addr, $urandom, 4'($urandom_range(0, 15)), $urandom);
            #1;
            exp = model_read(addr);
            checks++;
            if (bus.m_data_rdata !== exp) begin
                failures++;
                $display("FAIL rand_read %0d addr=%h: rdata=%h want %h", n, addr, bus.m_data_rdata, exp);
            end
            step();
            checks++;
            if (wr_count !== m_count || fault !== m_fault || ready !== 1'b1) begin
                failures++;
                $display("FAIL rand_state %0d: wr_count=%h fault=%b ready=%b want %h %b 1",
                         n, wr_count, fault, ready, m_count, m_fault);
            end
        end
    endtask

    task automatic test_fault();
        logic [31:0] word0, cnt0;
        // Clear any fault left over so the rising edge is observed here.
        reset = 1'b1;
        model_reset();
        #1;
        @(negedge clk);
        reset = 1'b0;
        drive(32'h0, 32'h0, 4'b0000, 32'h0);
        for (int c = 0; c < DEPTH; c++) step();
        drive(32'h0, 32'hCAFE_0001, 4'b1111, 32'h3100);
        step();
        word0 = m_mem[0];
        cnt0  = m_count;
        drive(32'h40, 32'h5555_AAAA, 4'b1111, 32'h3104);
        #1;
        checks++;
        if (bus.m_data_rdata !== 32'h0) begin
            failures++;
            $display("FAIL oor_read: rdata=%h want 00000000", bus.m_data_rdata);
        end
        step();
        checks++;
        if (fault !== 1'b1 || wr_count !== cnt0) begin
            failures++;
            $display("FAIL oor_store: fault=%b wr_count=%h want 1 %h", fault, wr_count, cnt0);
        end
        drive(32'h0, 32'h0, 4'b0000, 32'h3108);
        #1;
        checks++;
        if (bus.m_data_rdata !== word0) begin
            failures++;
            $display("FAIL oor_alias: rdata=%h want %h", bus.m_data_rdata, word0);
        end
        drive(32'hC, 32'h0BAD_F00D, 4'b0101, 32'h310C);
        step();
        checks++;
        if (fault !== 1'b1 || wr_count !== m_count) begin
            failures++;
            $display("FAIL fault_sticky: fault=%b wr_count=%h want 1 %h", fault, wr_count, m_count);
        end
    endtask

    task automatic test_reset_mid_clear();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(32'h0, 32'h0, 4'b0000, 32'h0);
        for (int c = 0; c < 5; c++) step();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0 || fault !== 1'b0 || wr_count !== 32'h0) begin
            failures++;
            $display("FAIL mid_clear_reset: ready=%b fault=%b wr_count=%h want 0 0 0", ready, fault, wr_count);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= DEPTH; c++) begin
            if (c <= 3) drive(32'hC, 32'hFFFF_FFFF, 4'b1111, 32'h3200);
            else drive(32'hC, 32'h0, 4'b0000, 32'h3200);
            step();
            checks++;
            if (ready !== m_ready || ready !== (c == DEPTH)) begin
                failures++;
                $display("FAIL reclear_ready cycle %0d: ready=%b want %b", c, ready, c == DEPTH);
            end
        end
        drive(32'hC, 32'h0, 4'b0000, 32'h3204);
        #1;
        checks++;
        if (bus.m_data_rdata !== 32'h0 || wr_count !== 32'h0 || fault !== 1'b0) begin
            failures++;
            $display("FAIL clear_drop: rdata=%h wr_count=%h fault=%b want 0 0 0",
                     bus.m_data_rdata, wr_count, fault);
        end
    endtask

    task automatic test_count_wrap();
        @(negedge clk);
        force dut.wr_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.wr_count_q;
        m_count = 32'hFFFF_FFFF;
        drive(32'h10, 32'h0000_0077, 4'b0001, 32'h3300);
        step();
        checks++;
        if (wr_count !== m_count || wr_count !== 32'h0) begin
            failures++;
            $display("FAIL count_wrap: wr_count=%h want 00000000", wr_count);
        end
        drive(32'h10, 32'h0, 4'b0000, 32'h3304);
        #1;
        checks++;
        if (bus.m_data_rdata !== 32'h0000_0077) begin
            failures++;
            $display("FAIL wrap_store: rdata=%h want 00000077", bus.m_data_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_byte_merge();
        test_read_during_write();
        test_random();
        test_fault();
        test_reset_mid_clear();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
- Word-organised data RAM that sits directly downstream of the pipelined CPU's M stage.
- Consumes the CPU's data-memory request: address, write data, byte enables and M-stage PC. Returns read data combinationally in the same cycle.
- After every reset, a clear FSM zeroes the array before ready is raised.
- Flags stores outside the mapped window and counts committed writes for bench checking.

Parameters:
DEPTH_WORDS, 4096, number of 32-bit words in the array (power of two).
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH_WORDS*4 aligned.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
m_data_addr  input  32  byte address from the M stage; bits [1:0] ignored.
m_data_wdata  input  32  store data, already lane-shifted by the CPU.
m_data_byteen  input  4  byte-lane write enables; 4'b0000 means read or no access.
m_inst_addr  input  32  PC of the M-stage instruction (trace use only).
m_data_rdata  output  32  word read data, combinational.
ready  output  1  high once the post-reset clear has completed.
fault  output  1  sticky flag: a store addressed outside the window.
wr_count  output  32  number of committed store cycles.

Behaviour:
- Reset values: ready=0, fault=0, wr_count=0, FSM=CLEAR, clear index=0. m_data_rdata is 0 while not ready.
- Window:
  - in_range = (m_data_addr - BASE_ADDR) < DEPTH_WORDS*4, computed unsigned in 32 bits.
  - word index = (m_data_addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits.
- FSM state CLEAR:
  - Each cycle, write 32'h0 to mem[idx], then idx <= idx+1.
  - When idx == DEPTH_WORDS-1 is written, go to RUN and set ready=1 on that same edge.
  - Clear takes exactly DEPTH_WORDS cycles after reset deasserts.
  - CPU stores during CLEAR are dropped: no array write, no count, no fault.
- FSM state RUN: stays in RUN until reset. No other transitions.
- Reads (RUN only):
  - m_data_rdata = mem[index] when in_range, else 32'h0. Pure combinational, no latency.
  - Read-during-write to the same word returns pre-edge contents; the new data is visible the next cycle.
- Writes (RUN, byteen != 0):
  - in_range: at the rising edge, each lane i with byteen[i]=1 takes wdata[8i+7:8i]; other lanes keep their value. wr_count <= wr_count+1, wrapping 32'hFFFF_FFFF -> 0.
  - out of range: array unchanged, wr_count unchanged, fault <= 1 and stays 1 until reset.
- Non-contiguous byteen patterns (e.g. 4'b1010) are honoured lane-wise without error.
- Reset mid-CLEAR or mid-RUN: immediately ready=0 and fault=0, FSM=CLEAR, idx=0. The clear restarts from word 0.

Optional Feature:
- Macro DM_TRACE_EN:
  - When defined: on every committed in-range store, simulation prints "@<m_inst_addr>: *<byte address of word> <= <merged 32-bit word>" (hex, 8 digits each), formatted for diffing against the reference simulator. Out-of-range stores print "@<pc>: DM FAULT <addr>".
  - When undefined: no print statements. m_inst_addr is functionally unused. Synthesised logic is identical.

Decomposition:
- Shared package holds:
  - FSM state encoding: CLEAR=1'b0, RUN=1'b1.
  - Default DEPTH_WORDS and BASE_ADDR constants.
  - A byte-merge function taking (old word, wdata, byteen) and returning the merged word. The CPU's store path uses the same function.
- One sub-module is natural: dm_array, the storage with a single write port (index, per-lane enables, data) and a combinational read port.
- data_mem keeps the FSM, window check, mux between clear and CPU write, counter and fault logic.

Test Plan:
- Release reset with DEPTH_WORDS=16 -> ready low for exactly 16 cycles, then high. Every in-range read returns 32'h0.
- After ready: store 32'hDEADBEEF, byteen 4'b1111, at address 0x8; next cycle store 32'h0000AA00, byteen 4'b0010, at 0x8 -> reading 0x8 returns 32'hDEADAAEF, wr_count=2.
- In the same cycle, store 32'h12345678 to 0x4 while reading 0x4 -> rdata shows old 32'h0; the following cycle shows 32'h12345678.
- Store to 0x40 with DEPTH_WORDS=16 -> fault=1, array unchanged, wr_count unchanged. Read of 0x40 returns 0. Fault stays set through later valid stores.
- Assert reset at clear cycle 5, release -> ready stays low a full 16 further cycles. Store issued during CLEAR is not counted and not visible after ready.
- Preload wr_count to 32'hFFFF_FFFF via forced state, then one valid store -> wr_count=0. With DM_TRACE_EN, log line "@00003000: *00000008 <= deadbeef" appears for the second scenario's first store when m_inst_addr=0x3000.
